baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 112 +++++++++++
 tb/tb_baud_gen_frac.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: phase accumulator producing rx (oversample) and tx (bit) strobes.
// Optional macro BAUD_GEN_FRAC_ZERO_GUARD_EN rejects zero increments and adds a cfg_err pulse output.
module baud_gen_frac #(
  parameter int               ACC_W      = 24,
  parameter int               OVERSAMPLE = 16,
  parameter logic [ACC_W-1:0] INCR_RST   = ACC_W'(25770)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_incr,
  output logic             cfg_ready,
  output logic             rx_tick,
  output logic             tx_tick
`ifdef BAUD_GEN_FRAC_ZERO_GUARD_EN
  ,
  output logic             cfg_err
`endif
);

  localparam int               SUB_W   = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(OVERSAMPLE - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] incr_act_q, incr_act_d;
  logic [ACC_W-1:0] incr_pend_q, incr_pend_d;
  logic             pend_q, pend_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             rx_tick_q, rx_tick_d;
  logic             tx_tick_q, tx_tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, incr_act_q};
    acc_d       = acc_q;
    incr_act_d  = incr_act_q;
    incr_pend_d = incr_pend_q;
    pend_d      = pend_q;
    sub_cnt_d   = sub_cnt_q;
    rx_tick_d   = 1'b0;
    tx_tick_d   = 1'b0;
    cfg_err_d   = 1'b0;

    if (en) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        rx_tick_d = 1'b1;
        if (sub_cnt_q == SUB_MAX) begin
          sub_cnt_d = '0;
          tx_tick_d = 1'b1;
        end else begin
          sub_cnt_d = sub_cnt_q + SUB_W'(1);
        end
      end
    end

    // A new rate takes effect on a bit boundary, or at once when nothing is counting.
    if (pend_q && (tx_tick_d || !en || (incr_act_q == '0))) begin
      incr_act_d = incr_pend_q;
      pend_d     = 1'b0;
    end

    if (cfg_valid && !pend_q) begin
`ifdef BAUD_GEN_FRAC_ZERO_GUARD_EN
      if (cfg_incr == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        incr_pend_d = cfg_incr;
        pend_d      = 1'b1;
      end
`else
      incr_pend_d = cfg_incr;
      pend_d      = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      incr_act_q  <= INCR_RST;
      incr_pend_q <= '0;
      pend_q      <= 1'b0;
      sub_cnt_q   <= '0;
      rx_tick_q   <= 1'b0;
      tx_tick_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      incr_act_q  <= incr_act_d;
      incr_pend_q <= incr_pend_d;
      pend_q      <= pend_d;
      sub_cnt_q   <= sub_cnt_d;
      rx_tick_q   <= rx_tick_d;
      tx_tick_q   <= tx_tick_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_q;
  assign rx_tick   = rx_tick_q;
  assign tx_tick   = tx_tick_q;
`ifdef BAUD_GEN_FRAC_ZERO_GUARD_EN
  assign cfg_err   = cfg_err_q;
`else
  logic unused_err;
  assign unused_err = cfg_err_q;
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac with ACC_W=16, OVERSAMPLE=4, INCR_RST=0x4000.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_incr = '0;
  logic        cfg_ready;
  logic        rx_tick;
  logic        tx_tick;
`ifdef BAUD_GEN_FRAC_ZERO_GUARD_EN
  logic        cfg_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  baud_gen_frac #(
    .ACC_W     (16),
    .OVERSAMPLE(4),
    .INCR_RST  (16'h4000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_incr (cfg_incr),
    .cfg_ready(cfg_ready),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick)
`ifdef BAUD_GEN_FRAC_ZERO_GUARD_EN
    ,
    .cfg_err  (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges; rx expected where i%per==ph (per=0: never), tx expected at edge txi.
  task automatic ticks(input string tag, input int n, input int per, input int ph, input int txi);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk({tag, "_rx"}, rx_tick, (per != 0) && ((i % per) == ph));
      chk({tag, "_tx"}, tx_tick, i == txi);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_rx", rx_tick, 1'b0);
    chk("rst_tx", tx_tick, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;

    ticks("init", 21, 4, 0, 16);

    en = 1'b0;
    ticks("hold", 7, 0, 0, 0);
    en = 1'b1;
    ticks("resume", 3, 3, 0, 0);

    cfg_valid = 1'b1;
    cfg_incr  = 16'h2000;
    chk("cfg_ready_idle", cfg_ready, 1'b1);
    tick();
    chk("cfg_ready_taken", cfg_ready, 1'b0);
    cfg_incr = 16'h1000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("pend_ready", cfg_ready, 1'b0);
      chk("pend_rx", rx_tick, i == 3);
      chk("pend_tx", tx_tick, 1'b0);
    end
    tick();
    chk("apply_rx", rx_tick, 1'b1);
    chk("apply_tx", tx_tick, 1'b1);
    chk("apply_ready", cfg_ready, 1'b1);
    cfg_valid = 1'b0;
    ticks("rate8", 32, 8, 0, 32);

    cfg_valid = 1'b1;
    cfg_incr  = 16'h1000;
    tick();
    chk("pre_rst_ready", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    ticks("pre_rst", 7, 7, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rx", rx_tick, 1'b0);
    chk("async_tx", tx_tick, 1'b0);
    chk("async_ready", cfg_ready, 1'b1);
    tick();
    chk("in_rst_ready", cfg_ready, 1'b1);
    rst = 1'b0;
    ticks("post_rst", 8, 4, 0, 0);
    chk("post_rst_ready", cfg_ready, 1'b1);

    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_incr  = 16'h5555;
    tick();
    chk("en0_rx_off", rx_tick, 1'b0);
    chk("en0_taken", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    tick();
    chk("en0_apply", cfg_ready, 1'b1);
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("frac_rx", rx_tick, (i == 4) || (i == 7) || (i == 10));
      chk("frac_tx", tx_tick, i == 7);
    end

    cfg_valid = 1'b1;
    cfg_incr  = 16'h0000;
    tick();
    cfg_valid = 1'b0;
    chk("zero_rx11", rx_tick, 1'b0);
`ifdef BAUD_GEN_FRAC_ZERO_GUARD_EN
    chk("zero_err", cfg_err, 1'b1);
    chk("zero_ready", cfg_ready, 1'b1);
    for (int i = 12; i <= 27; i++) begin
      tick();
      chk("zg_err", cfg_err, 1'b0);
      chk("zg_ready", cfg_ready, 1'b1);
      chk("zg_rx", rx_tick, (i == 13) || (i == 16) || (i == 19) || (i == 22) || (i == 25));
      chk("zg_tx", tx_tick, i == 19);
    end
`else
    chk("zero_taken", cfg_ready, 1'b0);
    for (int i = 12; i <= 27; i++) begin
      tick();
      chk("zero_ready", cfg_ready, i >= 19);
      chk("zero_rx", rx_tick, (i == 13) || (i == 16) || (i == 19));
      chk("zero_tx", tx_tick, i == 19);
    end
    cfg_valid = 1'b1;
    cfg_incr  = 16'hA000;
    chk("z_ready_idle", cfg_ready, 1'b1);
    tick();
    chk("z_taken", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    tick();
    chk("z_apply_ready", cfg_ready, 1'b1);
    chk("z_apply_rx", rx_tick, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("restart_rx", rx_tick, (i == 2) || (i == 3));
      chk("restart_tx", tx_tick, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
